// File: rtl/frontend_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// frontend_ctrl_pkg
// Shared types and defaults for the front-end sequencing controller.
//   fe_state_t   : controller states (STARTUP, RUN, HALT, FLUSH, REDIRECT)
//   redir_kind_t : redirect request kinds; the numeric order is the priority
//                  order, so "a >= b" means "a may replace b"
//   FE_FLUSH_CYCLES / FE_STARTUP_CYCLES : default phase lengths
//   fe_timer_width() : width of the shared phase down-counter
// ---------------------------------------------------------------------------
package frontend_ctrl_pkg;

    typedef enum logic [2:0] {
        FE_STARTUP  = 3'd0,
        FE_RUN      = 3'd1,
        FE_HALT     = 3'd2,
        FE_FLUSH    = 3'd3,
        FE_REDIRECT = 3'd4
    } fe_state_t;

    // NONE must stay at zero and EXC at the top: the arbiter relies on a
    // plain magnitude compare to decide replacement.
    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_JMP  = 2'd1,
        REDIR_BR   = 2'd2,
        REDIR_EXC  = 2'd3
    } redir_kind_t;

    localparam int FE_FLUSH_CYCLES   = 2;
    localparam int FE_STARTUP_CYCLES = 4;

    // The timer holds (cycles - 1) at most, so $clog2(max) bits suffice.
    function automatic int fe_timer_width(input int flush_cycles, input int startup_cycles);
        int max_cycles;
        max_cycles = (flush_cycles > startup_cycles) ? flush_cycles : startup_cycles;
        return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/frontend_ctrl_redirect_arbiter.sv
// ---------------------------------------------------------------------------
// frontend_ctrl_redirect_arbiter
// Combinational redirect arbitration for frontend_ctrl.
//   - Picks one same-cycle winner: exception > branch > jump.
//   - Decides whether the winner replaces the pending request (pending empty,
//     or winner priority >= pending priority) and produces the next value of
//     the pending register. The register itself lives in frontend_ctrl.
// Ports:
//   exc_req/exc_target, br_req/br_target, jmp_req/jmp_target : requests
//   pend_kind, pend_target : current pending register contents
//   consume         : 1 in the REDIRECT cycle; the pending entry is being
//                     issued, so it is treated as already empty
//   accept          : a request was latched this cycle
//   pend_kind_nxt, pend_target_nxt : next pending register contents
// ---------------------------------------------------------------------------
module frontend_ctrl_redirect_arbiter
    import frontend_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                exc_req,
    input  logic [PC_WIDTH-1:0] exc_target,
    input  logic                br_req,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                jmp_req,
    input  logic [PC_WIDTH-1:0] jmp_target,
    input  logic [1:0]          pend_kind,
    input  logic [PC_WIDTH-1:0] pend_target,
    input  logic                consume,
    output logic                accept,
    output logic [1:0]          pend_kind_nxt,
    output logic [PC_WIDTH-1:0] pend_target_nxt
);

    redir_kind_t         win_kind;
    logic [PC_WIDTH-1:0] win_target;
    redir_kind_t         held_kind;

    always_comb begin
        win_kind   = REDIR_NONE;
        win_target = '0;
        if (exc_req) begin
            win_kind   = REDIR_EXC;
            win_target = exc_target;
        end else if (br_req) begin
            win_kind   = REDIR_BR;
            win_target = br_target;
        end else if (jmp_req) begin
            win_kind   = REDIR_JMP;
            win_target = jmp_target;
        end

        held_kind = consume ? REDIR_NONE : redir_kind_t'(pend_kind);

        // Equal priority replaces: the newer request of the same kind wins.
        accept = (win_kind != REDIR_NONE) &&
                 ((held_kind == REDIR_NONE) || (win_kind >= held_kind));

        pend_kind_nxt   = held_kind;
        pend_target_nxt = pend_target;
        if (accept) begin
            pend_kind_nxt   = win_kind;
            pend_target_nxt = win_target;
        end
    end

endmodule

// File: rtl/frontend_ctrl.sv
// ---------------------------------------------------------------------------
// frontend_ctrl
// Sequencing controller for the front end (fetch -> IF/ID FIFO -> decode ->
// ID/MP FIFO -> map -> MP/RN FIFO -> rename). Owns the stage enables and
// stalls, the FIFO flush, and turns startup, halts and redirect requests into
// one ordered flush-then-redirect sequence.
//
// Request / pulse protocol: exc_req, br_req and jmp_req are sampled on every
// rising clock edge with rst=1; there is no back-pressure, a request either
// lands in the single pending register or is dropped on that same edge. The
// redirect itself is a one-cycle pulse (exception, branch or jump) that is the
// valid qualifier for pc_override; fetch must act on it in that cycle.
//
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   exc_req/exc_target  : exception redirect request and handler PC
//   br_req/br_target    : mispredicted-branch redirect and target
//   jmp_req/jmp_target  : jump redirect and target
//   halt_req            : level, keep the front end idle while 1
//   map_full, rs_full   : back-pressure from map free list / reservation stn
//   if_en, id_en        : fetch write enable, decode read enable
//   stall               : global front-end stall
//   if/id/mp/rn_stall   : per-stage stalls
//   fifo_flush          : synchronous clear of the three inter-stage FIFOs
//   branch/jump/exception : one-cycle redirect pulses
//   pc_override         : redirect PC, valid with a pulse, held otherwise
//   busy                : 1 in any state other than RUN
//   redirect_count      : saturating count of redirects issued
// All outputs are registered from the next state.
// ---------------------------------------------------------------------------
module frontend_ctrl
    import frontend_ctrl_pkg::*;
#(
    parameter int PC_WIDTH       = 32,
    parameter int FLUSH_CYCLES   = FE_FLUSH_CYCLES,
    parameter int STARTUP_CYCLES = FE_STARTUP_CYCLES,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exc_req,
    input  logic [PC_WIDTH-1:0]  exc_target,
    input  logic                 br_req,
    input  logic [PC_WIDTH-1:0]  br_target,
    input  logic                 jmp_req,
    input  logic [PC_WIDTH-1:0]  jmp_target,
    input  logic                 halt_req,
    input  logic                 map_full,
    input  logic                 rs_full,
    output logic                 if_en,
    output logic                 id_en,
    output logic                 stall,
    output logic                 if_stall,
    output logic                 id_stall,
    output logic                 mp_stall,
    output logic                 rn_stall,
    output logic                 fifo_flush,
    output logic                 branch,
    output logic                 jump,
    output logic                 exception,
    output logic [PC_WIDTH-1:0]  pc_override,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    localparam int                   TMR_W        = fe_timer_width(FLUSH_CYCLES, STARTUP_CYCLES);
    localparam logic [TMR_W-1:0]     FLUSH_LOAD   = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0]     STARTUP_LOAD = TMR_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

    fe_state_t           state;
    fe_state_t           state_nxt;
    logic [TMR_W-1:0]    tmr;
    logic [TMR_W-1:0]    tmr_nxt;
    redir_kind_t         pend_kind;
    logic [PC_WIDTH-1:0] pend_target;
    logic [1:0]          pend_kind_nxt;
    logic [PC_WIDTH-1:0] pend_target_nxt;
    logic                accept;
    logic                has_pend;

    frontend_ctrl_redirect_arbiter #(
        .PC_WIDTH (PC_WIDTH)
    ) u_arb (
        .exc_req         (exc_req),
        .exc_target      (exc_target),
        .br_req          (br_req),
        .br_target       (br_target),
        .jmp_req         (jmp_req),
        .jmp_target      (jmp_target),
        .pend_kind       (pend_kind),
        .pend_target     (pend_target),
        .consume         (state == FE_REDIRECT),
        .accept          (accept),
        .pend_kind_nxt   (pend_kind_nxt),
        .pend_target_nxt (pend_target_nxt)
    );

    // Includes a request captured on this very edge, so a request in RUN or
    // HALT moves to FLUSH on the same edge that latches it.
    assign has_pend = (pend_kind_nxt != REDIR_NONE);

    // Next state and phase timer. One timer serves both STARTUP and FLUSH;
    // it is loaded with (length - 1) and the phase ends on the edge that
    // sees it at zero.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        unique case (state)
            FE_STARTUP: begin
                if (tmr == '0) begin
                    if (has_pend) begin
                        state_nxt = FE_FLUSH;
                        tmr_nxt   = FLUSH_LOAD;
                    end else if (halt_req) begin
                        state_nxt = FE_HALT;
                    end else begin
                        state_nxt = FE_RUN;
                    end
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            FE_RUN, FE_HALT: begin
                if (has_pend) begin
                    state_nxt = FE_FLUSH;
                    tmr_nxt   = FLUSH_LOAD;
                end else if (halt_req) begin
                    state_nxt = FE_HALT;
                end else begin
                    state_nxt = FE_RUN;
                end
            end
            FE_FLUSH: begin
                // A newly accepted request restarts the flush so the younger
                // redirect still gets a full flush window.
                if (accept) begin
                    tmr_nxt = FLUSH_LOAD;
                end else if (tmr == '0) begin
                    state_nxt = FE_REDIRECT;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            FE_REDIRECT: begin
                if (accept) begin
                    state_nxt = FE_FLUSH;
                    tmr_nxt   = FLUSH_LOAD;
                end else if (halt_req) begin
                    state_nxt = FE_HALT;
                end else begin
                    state_nxt = FE_RUN;
                end
            end
            default: begin
                state_nxt = FE_STARTUP;
                tmr_nxt   = STARTUP_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= FE_STARTUP;
            tmr            <= STARTUP_LOAD;
            pend_kind      <= REDIR_NONE;
            pend_target    <= '0;
            redirect_count <= '0;
            pc_override    <= '0;
            if_en          <= 1'b0;
            id_en          <= 1'b0;
            stall          <= 1'b1;
            if_stall       <= 1'b0;
            id_stall       <= 1'b0;
            mp_stall       <= 1'b0;
            rn_stall       <= 1'b0;
            fifo_flush     <= 1'b0;
            branch         <= 1'b0;
            jump           <= 1'b0;
            exception      <= 1'b0;
            busy           <= 1'b1;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            pend_kind   <= redir_kind_t'(pend_kind_nxt);
            pend_target <= pend_target_nxt;

            // Idle defaults (STARTUP and HALT look like this).
            if_en      <= 1'b0;
            id_en      <= 1'b0;
            stall      <= 1'b1;
            if_stall   <= 1'b0;
            id_stall   <= 1'b0;
            mp_stall   <= 1'b0;
            rn_stall   <= 1'b0;
            fifo_flush <= 1'b0;
            branch     <= 1'b0;
            jump       <= 1'b0;
            exception  <= 1'b0;
            busy       <= 1'b1;

            unique case (state_nxt)
                FE_RUN: begin
                    if_en    <= 1'b1;
                    id_en    <= 1'b1;
                    stall    <= 1'b0;
                    mp_stall <= map_full;
                    rn_stall <= rs_full;
                    busy     <= 1'b0;
                end
                FE_FLUSH: begin
                    fifo_flush <= 1'b1;
                    if_stall   <= 1'b1;
                    id_stall   <= 1'b1;
                    mp_stall   <= 1'b1;
                    rn_stall   <= 1'b1;
                end
                FE_REDIRECT: begin
                    // Only reachable from FLUSH without a same-edge accept,
                    // so the current pending entry is the one to issue.
                    stall       <= 1'b0;
                    exception   <= (pend_kind == REDIR_EXC);
                    branch      <= (pend_kind == REDIR_BR);
                    jump        <= (pend_kind == REDIR_JMP);
                    pc_override <= pend_target;
                    if (redirect_count != CNT_MAX) begin
                        redirect_count <= redirect_count + CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frontend_ctrl.sv
// Scoreboard bench for frontend_ctrl. A reference model steps once per rising
// edge from the sampled inputs and pushes the expected output word for the
// following cycle; redirect pulses additionally push an expected redirect
// record. A monitor on the falling edge pops and compares.
module tb_frontend_ctrl;

    localparam int PC_W     = 32;
    localparam int FLUSH_C  = 2;
    localparam int START_C  = 4;
    localparam int CNT_W    = 2;
    localparam int CTRL_W   = 12 + CNT_W + PC_W;
    localparam int RED_W    = 3 + PC_W + CNT_W;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             exc_req, br_req, jmp_req;
    logic [PC_W-1:0]  exc_target, br_target, jmp_target;
    logic             halt_req, map_full, rs_full;
    logic             if_en, id_en, stall;
    logic             if_stall, id_stall, mp_stall, rn_stall;
    logic             fifo_flush, branch, jump, exception;
    logic [PC_W-1:0]  pc_override;
    logic             busy;
    logic [CNT_W-1:0] redirect_count;

    frontend_ctrl #(
        .PC_WIDTH       (PC_W),
        .FLUSH_CYCLES   (FLUSH_C),
        .STARTUP_CYCLES (START_C),
        .CNT_WIDTH      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_req        (exc_req),
        .exc_target     (exc_target),
        .br_req         (br_req),
        .br_target      (br_target),
        .jmp_req        (jmp_req),
        .jmp_target     (jmp_target),
        .halt_req       (halt_req),
        .map_full       (map_full),
        .rs_full        (rs_full),
        .if_en          (if_en),
        .id_en          (id_en),
        .stall          (stall),
        .if_stall       (if_stall),
        .id_stall       (id_stall),
        .mp_stall       (mp_stall),
        .rn_stall       (rn_stall),
        .fifo_flush     (fifo_flush),
        .branch         (branch),
        .jump           (jump),
        .exception      (exception),
        .pc_override    (pc_override),
        .busy           (busy),
        .redirect_count (redirect_count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [CTRL_W-1:0] exp_q[$];
    logic [RED_W-1:0]  red_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    // Phase bookkeeping: startup_left / flush_left count remaining cycles of
    // those phases; in_redir marks the single redirect cycle; halted says the
    // idle phase after RUN. Priority: exception=3, branch=2, jump=1, none=0.
    int              m_startup_left;
    int              m_flush_left;
    bit              m_in_redir;
    bit              m_halted;
    int              m_pend;
    logic [PC_W-1:0] m_tgt;
    logic [PC_W-1:0] m_pc;
    int              m_count;

    always @(posedge clk) begin : model
        int              win;
        int              held;
        bit              acc;
        logic [PC_W-1:0] wt;
        bit e_if, e_id, e_st, e_ifs, e_ids, e_mps, e_rns, e_fl, e_busy;
        bit e_exc, e_br, e_jmp;

        if (!rst) begin
            m_startup_left = START_C;
            m_flush_left   = 0;
            m_in_redir     = 0;
            m_halted       = 0;
            m_pend         = 0;
            m_tgt          = '0;
            m_pc           = '0;
            m_count        = 0;
        end else begin
            win = exc_req ? 3 : br_req ? 2 : jmp_req ? 1 : 0;
            wt  = exc_req ? exc_target : br_req ? br_target : jmp_target;
            // The entry being issued this cycle no longer blocks newcomers.
            held = m_in_redir ? 0 : m_pend;
            acc  = (win != 0) && (held == 0 || win >= held);
            if (m_in_redir) m_pend = 0;
            if (acc) begin
                m_pend = win;
                m_tgt  = wt;
            end

            if (m_startup_left > 0) begin
                m_startup_left--;
                if (m_startup_left == 0) begin
                    if (m_pend != 0) m_flush_left = FLUSH_C;
                    else             m_halted = halt_req;
                end
            end else if (m_flush_left > 0) begin
                if (acc) begin
                    m_flush_left = FLUSH_C;
                end else begin
                    m_flush_left--;
                    if (m_flush_left == 0) begin
                        m_in_redir = 1;
                        m_pc       = m_tgt;
                        if (m_count < CNT_SAT) m_count++;
                        red_q.push_back({(m_pend == 3), (m_pend == 2), (m_pend == 1),
                                         m_tgt, CNT_W'(m_count)});
                    end
                end
            end else if (m_in_redir) begin
                m_in_redir = 0;
                if (acc) m_flush_left = FLUSH_C;
                else     m_halted = halt_req;
            end else begin
                if (m_pend != 0) begin
                    m_flush_left = FLUSH_C;
                    m_halted     = 0;
                end else begin
                    m_halted = halt_req;
                end
            end
        end

        {e_if, e_id, e_ifs, e_ids, e_mps, e_rns, e_fl, e_exc, e_br, e_jmp} = '0;
        e_st   = 1;
        e_busy = 1;
        if (m_startup_left > 0) begin
            // startup / reset: idle with global stall
        end else if (m_flush_left > 0) begin
            e_fl = 1;
            {e_ifs, e_ids, e_mps, e_rns} = 4'b1111;
        end else if (m_in_redir) begin
            e_st  = 0;
            e_exc = (m_pend == 3);
            e_br  = (m_pend == 2);
            e_jmp = (m_pend == 1);
        end else if (m_halted) begin
            // halted: idle with global stall
        end else begin
            e_if   = 1;
            e_id   = 1;
            e_st   = 0;
            e_busy = 0;
            e_mps  = map_full;
            e_rns  = rs_full;
        end
        exp_q.push_back({e_exc, e_br, e_jmp, e_if, e_id, e_st, e_ifs, e_ids, e_mps, e_rns,
                         e_fl, e_busy, CNT_W'(m_count), m_pc});
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [CTRL_W-1:0] got, want;
        logic [RED_W-1:0]  rgot, rwant;
        cyc++;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got  = {exception, branch, jump, if_en, id_en, stall, if_stall, id_stall,
                    mp_stall, rn_stall, fifo_flush, busy, redirect_count, pc_override};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ctrl cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
        if (exception || branch || jump) begin
            rgot = {exception, branch, jump, pc_override, redirect_count};
            total++;
            if (red_q.size() == 0) begin
                bad++;
                $display("FAIL redirect cyc=%0d got=%h exp=none", cyc, rgot);
            end else begin
                rwant = red_q.pop_front();
                if (rgot !== rwant) begin
                    bad++;
                    $display("FAIL redirect cyc=%0d got=%h exp=%h", cyc, rgot, rwant);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit e, input bit b, input bit j,
                         input logic [PC_W-1:0] et, input logic [PC_W-1:0] bt,
                         input logic [PC_W-1:0] jt);
        exc_req    = e;
        br_req     = b;
        jmp_req    = j;
        exc_target = et;
        br_target  = bt;
        jmp_target = jt;
        step(1);
        exc_req = 0;
        br_req  = 0;
        jmp_req = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 0;
        exc_req    = 0;
        br_req     = 0;
        jmp_req    = 0;
        exc_target = '0;
        br_target  = '0;
        jmp_target = '0;
        halt_req   = 0;
        map_full   = 0;
        rs_full    = 0;

        // Reset for three cycles, then startup into RUN.
        step(3);
        rst = 1;
        step(7);

        // Single branch redirect.
        issue(0, 1, 0, 32'h0, 32'h100, 32'h0);
        step(5);

        // Three requests in one cycle: exception wins.
        issue(1, 1, 1, 32'h80, 32'h200, 32'h300);
        step(5);

        // Branch, then exception extends the flush, then a dropped jump.
        issue(0, 1, 0, 32'h0, 32'h100, 32'h0);
        issue(1, 0, 0, 32'h80, 32'h0, 32'h0);
        issue(0, 0, 1, 32'h0, 32'h0, 32'h300);
        step(6);

        // Halt, redirect while halted, return to halt, then release.
        halt_req = 1;
        step(3);
        issue(0, 0, 1, 32'h0, 32'h0, 32'h40);
        step(6);
        halt_req = 0;
        step(3);

        // Reset in the middle of a flush: no redirect may follow.
        issue(0, 1, 0, 32'h0, 32'h500, 32'h0);
        rst = 0;
        step(1);
        rst = 1;
        step(8);

        // Five redirects drive the 2-bit counter into saturation.
        for (int i = 0; i < 5; i++) begin
            issue(0, 0, 1, 32'h0, 32'h0, $urandom & 32'hffff_fffc);
            step(4);
        end

        // Stage stalls follow back-pressure one cycle later.
        rs_full = 1;
        step(2);
        rs_full  = 0;
        map_full = 1;
        step(2);
        map_full = 0;
        step(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
            map_full   = ($urandom_range(0, 3) == 0);
            rs_full    = ($urandom_range(0, 3) == 0);
            exc_req    = ($urandom_range(0, 19) == 0);
            br_req     = ($urandom_range(0, 11) == 0);
            jmp_req    = ($urandom_range(0, 11) == 0);
            exc_target = $urandom;
            br_target  = $urandom;
            jmp_target = $urandom;
            step(1);
        end

        rst      = 1;
        exc_req  = 0;
        br_req   = 0;
        jmp_req  = 0;
        halt_req = 0;
        map_full = 0;
        rs_full  = 0;
        step(12);
        @(negedge clk);
        #1;

        total++;
        if (red_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d exp=0/0", red_q.size(), exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
